// File: rtl/ps2_pkg.sv
// Purpose: shared types and constants for the PS/2 receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a; the PS/2 device cannot be stalled.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

    // PS/2 uses odd parity over the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Purpose: 2-FF synchroniser plus run-length glitch filter for one PS/2 pin.
// Latency: 2 + FILTER_LEN clk cycles from pin change to filtered output change.
// Backpressure: none; free-running on every clk.
//
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset (filtered level resets to 1)
//   din   in  raw pin, asynchronous to clk
//   dout  out filtered, clk-synchronous level
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            dout   <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], din};
            // The output only moves after FILTER_LEN consecutive samples that
            // disagree with it; any agreeing sample restarts the run.
            if (sync_q[1] != dout) begin
                if (cnt_q == CNT_LAST) begin
                    dout  <= sync_q[1];
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_frame_receiver.sv
// Purpose: PS/2 receive front end; de-glitches the pins, assembles and checks 11-bit frames.
// Latency: pin-to-strobe 2+FILTER_LEN+1 clk cycles (+1 for pin sampling phase).
// Backpressure: none; code_valid is a 1-cycle strobe the consumer must take when it fires.
//
// Ports:
//   clk, rst_n                   system clock, asynchronous active-low reset
//   Keyboard_clock, Keyboard_Data raw PS/2 pins (asynchronous)
//   code / code_valid            last accepted scan code and its 1-cycle strobe
//   is_break / is_extended       F0 / E0 prefix seen before code (prefix merge builds only)
//   frame_err                    1-cycle pulse on start, parity, stop or timeout error
//   busy                         high while a frame is being received
// Build option: define PS2_PREFIX_MERGE_EN to fold E0/F0 prefixes into the next code.
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Keyboard_clock,
    input  logic       Keyboard_Data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic filt_clk, filt_dat, filt_clk_prev, fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (Keyboard_clock),
        .dout  (filt_clk)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (Keyboard_Data),
        .dout  (filt_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) filt_clk_prev <= 1'b1;
        else        filt_clk_prev <= filt_clk;
    end

    // Combinational so the FSM consumes the bit in the same cycle the fall appears.
    assign fall = filt_clk_prev & ~filt_clk;

    ps2_state_t    state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          accept, err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tmo_d    = tmo_q;
        accept   = 1'b0;
        err      = 1'b0;

        if (state_q != IDLE) tmo_d = tmo_q + 1'b1;

        // A fall in the same cycle as the timeout wins: it proves the device is alive.
        if (fall) begin
            tmo_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (!filt_dat) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end else begin
                        err = 1'b1;
                    end
                end
                DATA: begin
                    shift_d = {filt_dat, shift_q[7:1]};
                    if (bitcnt_q == 3'd7) state_d  = PARITY;
                    else                  bitcnt_d = bitcnt_q + 1'b1;
                end
                PARITY: begin
                    par_d   = filt_dat;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (filt_dat && odd_parity_ok(shift_q, par_q)) accept = 1'b1;
                    else                                           err    = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tmo_q == TMO_LAST) begin
            state_d = IDLE;
            tmo_d   = '0;
            err     = 1'b1;
        end
    end

    assign busy = (state_q != IDLE);

`ifdef PS2_PREFIX_MERGE_EN
    logic ext_pend, brk_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code        <= 8'h00;
            code_valid  <= 1'b0;
            frame_err   <= 1'b0;
            is_break    <= 1'b0;
            is_extended <= 1'b0;
            ext_pend    <= 1'b0;
            brk_pend    <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (err) begin
                frame_err <= 1'b1;
                ext_pend  <= 1'b0;
                brk_pend  <= 1'b0;
            end else if (accept) begin
                if (shift_q == PS2_PREFIX_EXT) begin
                    ext_pend <= 1'b1;
                end else if (shift_q == PS2_PREFIX_BRK) begin
                    brk_pend <= 1'b1;
                end else begin
                    code        <= shift_q;
                    is_extended <= ext_pend;
                    is_break    <= brk_pend;
                    code_valid  <= 1'b1;
                    ext_pend    <= 1'b0;
                    brk_pend    <= 1'b0;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code       <= 8'h00;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= accept;
            frame_err  <= err;
            if (accept) code <= shift_q;
        end
    end

    assign is_break    = 1'b0;
    assign is_extended = 1'b0;
`endif

endmodule
